uart_led_cmd_ctrl: RTL and testbench

Command controller between the UART receiver and the 6-bit LED output. Consumes received bytes (valid/data/frame-error) and parses fixed 4-byte frames: header, command, argument, checksum. Validated commands update an LED register and a blink mask. A free-running blink generator drives the final led port; malformed or stalled frames are dropped and counted.

---
 rtl/uart_led_pkg.sv | 21 ++
 rtl/led_blink_gen.sv | 26 ++
 rtl/uart_led_cmd_ctrl.sv | 114 +++++++++++
 tb/tb_uart_led_cmd_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_led_pkg.sv
// Shared constants and types for the UART LED command controller.
package uart_led_pkg;

   localparam logic [7:0] HDR_BYTE  = 8'hA5;
   localparam logic [7:0] CMD_SET   = 8'h01;
   localparam logic [7:0] CMD_XOR   = 8'h02;
   localparam logic [7:0] CMD_BLINK = 8'h03;
   localparam logic [7:0] CMD_CLEAR = 8'h04;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GET_CMD = 2'd1,
      GET_ARG = 2'd2,
      GET_CHK = 2'd3
   } state_t;

   function automatic logic is_known_cmd(input logic [7:0] c);
      return (c == CMD_SET) || (c == CMD_XOR) || (c == CMD_BLINK) || (c == CMD_CLEAR);
   endfunction

endpackage

// File: rtl/led_blink_gen.sv
// Free-running blink phase: toggles every BLINK_DIV clock cycles.
module led_blink_gen #(
   parameter int BLINK_DIV = 12500000
) (
   input  logic clk,
   input  logic rst,
   output logic blink_phase
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         blink_phase <= 1'b0;
      end else if (cnt == CW'(BLINK_DIV - 1)) begin
         cnt         <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Parses 4-byte UART frames (A5, CMD, ARG, CMD^ARG) and drives a blinking 6-bit LED bank.
// Handshake: a byte is consumed on every clk edge with rx_valid=1 (no backpressure); rx_frame_err qualifies that byte.
module uart_led_cmd_ctrl
   import uart_led_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 520800,
   parameter int BLINK_DIV      = 12500000,
   parameter int LED_W          = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             rx_frame_err,
   output logic [LED_W-1:0] led,
   output logic             busy,
   output logic             cmd_ok,
   output logic             cmd_err,
   output logic [7:0]       err_count,
   output logic [1:0]       fsm_state
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t           state;
   logic [TW-1:0]    to_cnt;
   logic [7:0]       cmd;
   logic [7:0]       arg;
   logic [LED_W-1:0] led_reg;
   logic [LED_W-1:0] blink_mask;
   logic             blink_phase;

   logic clean, timeout, chk_clean, exec, drop;

   // Timeout fires on the edge where the idle count would reach TIMEOUT_CYCLES-1; a byte on that edge wins.
   assign clean     = rx_valid & ~rx_frame_err;
   assign timeout   = (state != IDLE) & ~rx_valid & (to_cnt == TW'(TIMEOUT_CYCLES - 2));
   assign chk_clean = (state == GET_CHK) & clean;
   assign exec      = chk_clean & (rx_data == (cmd ^ arg)) & is_known_cmd(cmd);
   assign drop      = ((state != IDLE) & rx_valid & rx_frame_err) | timeout | (chk_clean & ~exec);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         to_cnt     <= '0;
         cmd        <= '0;
         arg        <= '0;
         led_reg    <= '0;
         blink_mask <= '0;
         cmd_ok     <= 1'b0;
         cmd_err    <= 1'b0;
         err_count  <= '0;
      end else begin
         cmd_ok  <= exec;
         cmd_err <= drop;
         if (drop && err_count != 8'hFF)
            err_count <= err_count + 8'd1;

         if (state == IDLE || rx_valid || timeout)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;

         unique case (state)
            IDLE:    if (clean && rx_data == HDR_BYTE) state <= GET_CMD;
            GET_CMD: if (rx_valid) begin
                        if (rx_frame_err) state <= IDLE;
                        else begin
                           cmd   <= rx_data;
                           state <= GET_ARG;
                        end
                     end
            GET_ARG: if (rx_valid) begin
                        if (rx_frame_err) state <= IDLE;
                        else begin
                           arg   <= rx_data;
                           state <= GET_CHK;
                        end
                     end
            GET_CHK: if (rx_valid) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (timeout)
            state <= IDLE;

         if (exec) begin
            case (cmd)
               CMD_SET: begin
                  led_reg    <= arg[LED_W-1:0];
                  blink_mask <= '0;
               end
               CMD_XOR:   led_reg    <= led_reg ^ arg[LED_W-1:0];
               CMD_BLINK: blink_mask <= arg[LED_W-1:0];
               CMD_CLEAR: begin
                  led_reg    <= '0;
                  blink_mask <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   led_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
      .clk         (clk),
      .rst         (rst),
      .blink_phase (blink_phase)
   );

   assign led       = led_reg ^ (blink_mask & {LED_W{blink_phase}});
   assign busy      = (state != IDLE);
   assign fsm_state = state;

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Directed bench for uart_led_cmd_ctrl with a cycle-count model of the blink phase.
module tb_uart_led_cmd_ctrl;

   localparam int TIMEOUT_CYCLES = 50;
   localparam int BLINK_DIV      = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_frame_err;
   logic [5:0] led;
   logic       busy, cmd_ok, cmd_err;
   logic [7:0] err_count;
   logic [1:0] fsm_state;

   int checks   = 0;
   int failures = 0;
   int cyc;
   logic [5:0] exp_reg, exp_mask;

   uart_led_cmd_ctrl #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .BLINK_DIV      (BLINK_DIV),
      .LED_W          (6)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_frame_err (rx_frame_err),
      .led          (led),
      .busy         (busy),
      .cmd_ok       (cmd_ok),
      .cmd_err      (cmd_err),
      .err_count    (err_count),
      .fsm_state    (fsm_state)
   );

   // clock / reset bookkeeping
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [5:0] exp_led();
      logic phase;
      phase = (((cyc / BLINK_DIV) % 2) == 1);
      return exp_reg ^ (exp_mask & {6{phase}});
   endfunction

   // driver tasks: called at a negedge, return at the negedge after the accepting posedge
   task automatic send_byte(input logic [7:0] b, input logic fe = 1'b0);
      rx_valid     = 1'b1;
      rx_data      = b;
      rx_frame_err = fe;
      @(negedge clk);
      rx_valid     = 1'b0;
      rx_frame_err = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
      send_byte(8'hA5);
      send_byte(c);
      send_byte(a);
      send_byte(k);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_frame_err = 1'b0;
      exp_reg = 6'h00; exp_mask = 6'h00;
      idle(3);
      checks++; if (led !== 6'h00) begin failures++; $display("FAIL reset_led got=%h exp=00", led); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (cmd_ok !== 1'b0 || cmd_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", cmd_ok, cmd_err); end
      checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
      checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_set();
      send_byte(8'hA5);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL set_busy_hdr got=%b exp=1", busy); end
      send_byte(8'h01);
      send_byte(8'h2A);
      send_byte(8'h2B);
      exp_reg = 6'h2A; exp_mask = 6'h00;
      checks++; if (cmd_ok !== 1'b1 || cmd_err !== 1'b0) begin failures++; $display("FAIL set_pulse got=%b%b exp=10", cmd_ok, cmd_err); end
      checks++; if (led !== 6'h2A) begin failures++; $display("FAIL set_led got=%h exp=2a", led); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL set_busy got=%b exp=0", busy); end
      checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL set_err_count got=%0d exp=0", err_count); end
      idle(1);
      checks++; if (cmd_ok !== 1'b0) begin failures++; $display("FAIL set_pulse_width got=%b exp=0", cmd_ok); end
   endtask

   task automatic test_xor_blink();
      int toggles;
      logic prev;
      send_frame(8'h02, 8'h0F, 8'h0D);
      exp_reg = 6'h25;
      checks++; if (cmd_ok !== 1'b1) begin failures++; $display("FAIL xor_pulse got=%b exp=1", cmd_ok); end
      checks++; if (led !== 6'h25) begin failures++; $display("FAIL xor_led got=%h exp=25", led); end
      send_frame(8'h03, 8'h01, 8'h02);
      exp_mask = 6'h01;
      checks++; if (cmd_ok !== 1'b1) begin failures++; $display("FAIL blink_pulse got=%b exp=1", cmd_ok); end
      checks++; if (led !== exp_led()) begin failures++; $display("FAIL blink_led0 got=%h exp=%h", led, exp_led()); end
      toggles = 0;
      prev = led[0];
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         checks++; if (led !== exp_led()) begin failures++; $display("FAIL blink_led cyc=%0d got=%h exp=%h", i, led, exp_led()); end
         if (led[0] !== prev) toggles++;
         prev = led[0];
      end
      checks++; if (toggles != 3) begin failures++; $display("FAIL blink_toggles got=%0d exp=3", toggles); end
   endtask

   task automatic test_bad_frames();
      send_frame(8'h01, 8'h3F, 8'h00);
      checks++; if (cmd_err !== 1'b1 || cmd_ok !== 1'b0) begin failures++; $display("FAIL badchk_pulse got=%b%b exp=01", cmd_ok, cmd_err); end
      checks++; if (led !== exp_led()) begin failures++; $display("FAIL badchk_led got=%h exp=%h", led, exp_led()); end
      checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL badchk_err_count got=%0d exp=1", err_count); end
      send_frame(8'h07, 8'h00, 8'h07);
      checks++; if (cmd_err !== 1'b1 || cmd_ok !== 1'b0) begin failures++; $display("FAIL badop_pulse got=%b%b exp=01", cmd_ok, cmd_err); end
      checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL badop_err_count got=%0d exp=2", err_count); end
      checks++; if (led !== exp_led()) begin failures++; $display("FAIL badop_led got=%h exp=%h", led, exp_led()); end
   endtask

   task automatic test_timeout();
      int n;
      send_byte(8'hA5);
      send_byte(8'h01);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_busy got=%b exp=1", busy); end
      n = 0;
      while (cmd_err !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n != 49) begin failures++; $display("FAIL to_latency got=%0d exp=49", n); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy_after got=%b exp=0", busy); end
      checks++; if (err_count !== 8'd3) begin failures++; $display("FAIL to_err_count got=%0d exp=3", err_count); end
      idle(11);
      checks++; if (cmd_err !== 1'b0) begin failures++; $display("FAIL to_no_repeat got=%b exp=0", cmd_err); end
      send_frame(8'h01, 8'h15, 8'h14);
      exp_reg = 6'h15; exp_mask = 6'h00;
      checks++; if (cmd_ok !== 1'b1) begin failures++; $display("FAIL to_recover_pulse got=%b exp=1", cmd_ok); end
      checks++; if (led !== 6'h15) begin failures++; $display("FAIL to_recover_led got=%h exp=15", led); end
   endtask

   task automatic test_frame_err();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h2A, 1'b1);
      checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL ferr_pulse got=%b exp=1", cmd_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%b exp=0", busy); end
      checks++; if (err_count !== 8'd4) begin failures++; $display("FAIL ferr_err_count got=%0d exp=4", err_count); end
      send_byte(8'h33);
      checks++; if (cmd_err !== 1'b0 || cmd_ok !== 1'b0) begin failures++; $display("FAIL stray_pulse got=%b%b exp=00", cmd_ok, cmd_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stray_busy got=%b exp=0", busy); end
      send_byte(8'hA5, 1'b1);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_hdr_busy got=%b exp=0", busy); end
      checks++; if (err_count !== 8'd4 || cmd_err !== 1'b0) begin failures++; $display("FAIL ferr_idle got=%0d/%b exp=4/0", err_count, cmd_err); end
      checks++; if (led !== 6'h15) begin failures++; $display("FAIL ferr_led got=%h exp=15", led); end
   endtask

   task automatic test_back_to_back();
      send_frame(8'h04, 8'h00, 8'h04);
      exp_reg = 6'h00; exp_mask = 6'h00;
      checks++; if (cmd_ok !== 1'b1 || led !== 6'h00) begin failures++; $display("FAIL b2b_clear got=%b/%h exp=1/00", cmd_ok, led); end
      send_frame(8'h01, 8'h0A, 8'h0B);
      checks++; if (cmd_ok !== 1'b1 || led !== 6'h0A) begin failures++; $display("FAIL b2b_set got=%b/%h exp=1/0a", cmd_ok, led); end
      // A5 as ARG is data, not a resync
      send_frame(8'h01, 8'hA5, 8'hA4);
      exp_reg = 6'h25;
      checks++; if (cmd_ok !== 1'b1 || led !== 6'h25) begin failures++; $display("FAIL b2b_a5_arg got=%b/%h exp=1/25", cmd_ok, led); end
      checks++; if (err_count !== 8'd4) begin failures++; $display("FAIL b2b_err_count got=%0d exp=4", err_count); end
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'h03, 8'h3F, 8'h3C);
      exp_mask = 6'h3F;
      checks++; if (cmd_ok !== 1'b1) begin failures++; $display("FAIL rstmid_blink_pulse got=%b exp=1", cmd_ok); end
      idle(5);
      checks++; if (led !== exp_led()) begin failures++; $display("FAIL rstmid_blink_led got=%h exp=%h", led, exp_led()); end
      send_byte(8'hA5);
      send_byte(8'h02);
      checks++; if (fsm_state !== 2'd2 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_state got=%0d/%b exp=2/1", fsm_state, busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_reg = 6'h00; exp_mask = 6'h00;
      checks++; if (led !== 6'h00) begin failures++; $display("FAIL rstmid_led got=%h exp=00", led); end
      checks++; if (busy !== 1'b0 || fsm_state !== 2'd0) begin failures++; $display("FAIL rstmid_busy got=%b/%0d exp=0/0", busy, fsm_state); end
      checks++; if (cmd_err !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL rstmid_err got=%b/%0d exp=0/0", cmd_err, err_count); end
      idle(3);
      checks++; if (cmd_err !== 1'b0 || led !== 6'h00) begin failures++; $display("FAIL rstmid_after got=%b/%h exp=0/00", cmd_err, led); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 260; i++) begin
         send_byte(8'hA5);
         send_byte(8'h00, 1'b1);
         if (i == 253) begin
            checks++; if (err_count !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", err_count); end
         end
         if (i == 254) begin
            checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", err_count); end
         end
      end
      checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", err_count); end
      checks++; if (cmd_err !== 1'b1) begin failures++; $display("FAIL sat_pulse got=%b exp=1", cmd_err); end
      checks++; if (led !== 6'h00) begin failures++; $display("FAIL sat_led got=%h exp=00", led); end
   endtask

   initial begin
      test_reset();
      test_set();
      test_xor_blink();
      test_bad_frames();
      test_timeout();
      test_frame_err();
      test_back_to_back();
      test_reset_mid_frame();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
